// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the EX/MEM and MEM/WB registers.
// Holds a word-addressed data memory with a fixed MEM_LAT-cycle access time
// and stalls the upstream pipeline while an access is in flight.
// Optional build macro: MEM_STAGE_STATS_EN (completed load/store counters).
//
// Handshake: mem_stall acts as an inverted ready toward EX/MEM. While it is 1
// the upstream stages must hold their contents; an instruction counts as
// consumed on the rising edge where mem_stall is 0. A memory operation keeps
// mem_stall high for exactly MEM_LAT cycles starting with its accept cycle.
module mem_stage #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_WRegEn,
  input  logic              MEM_WMemEn,
  input  logic              MEM_RMemEn,
  input  logic [DATA_W-1:0] MEM_R1out,
  input  logic [DATA_W-1:0] MEM_R2out,
  input  logic [REG_W-1:0]  MEM_WReg1,
  input  logic [DATA_W-1:0] MEM_Z,
  output logic              mem_stall,
  output logic              WB_WRegEn,
  output logic [REG_W-1:0]  WB_WReg1,
  output logic [DATA_W-1:0] WB_WData,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              memop;
  logic              accept;
  logic              complete;

  // Operation captured at accept and replayed on the completing edge.
  logic [ADDR_W-1:0] lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] lat_z;
  logic [REG_W-1:0]  lat_reg1;
  logic              lat_regen;
  logic              lat_store;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Upper address bits are intentionally ignored so the index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = |MEM_R1out[DATA_W-1:ADDR_W];

  assign memop = MEM_WMemEn | MEM_RMemEn;

  // Next-state, stall and phase strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_stall = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          mem_stall = 1'b1;
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt - 4'd1;
        end else begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the memory operation when it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_z     <= '0;
      lat_reg1  <= '0;
      lat_regen <= 1'b0;
      lat_store <= 1'b0;
    end else if (accept) begin
      lat_idx   <= MEM_R1out[ADDR_W-1:0];
      lat_data  <= MEM_R2out;
      lat_z     <= MEM_Z;
      lat_reg1  <= MEM_WReg1;
      lat_regen <= MEM_WRegEn;
      lat_store <= MEM_WMemEn;
    end
  end

  // Memory write on the completing edge of a store; reset discards it.
  always_ff @(posedge clk) begin
    if (!reset && complete && lat_store) begin
      mem[lat_idx] <= lat_data;
    end
  end

  // Write-back register: pass-through, bubble while busy, result on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      WB_WRegEn <= 1'b0;
      WB_WReg1  <= '0;
      WB_WData  <= '0;
    end else if (state == IDLE && !memop) begin
      WB_WRegEn <= MEM_WRegEn;
      WB_WReg1  <= MEM_WReg1;
      WB_WData  <= MEM_Z;
    end else if (complete) begin
      WB_WRegEn <= lat_regen;
      WB_WReg1  <= lat_reg1;
      WB_WData  <= lat_store ? lat_z : mem[lat_idx];
    end else begin
      WB_WRegEn <= 1'b0;
    end
  end

`ifdef MEM_STAGE_STATS_EN
  // Saturating counters of completed loads and stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_count <= 32'd0;
      st_count <= 32'd0;
    end else if (complete) begin
      if (lat_store && st_count != 32'hFFFF_FFFF) st_count <= st_count + 32'd1;
      if (!lat_store && ld_count != 32'hFFFF_FFFF) ld_count <= ld_count + 32'd1;
    end
  end
`else
  assign ld_count = 32'd0;
  assign st_count = 32'd0;
`endif

endmodule
